// File: rtl/haar_integral_builder.sv
// haar_integral_builder: accumulates a WIN_W x WIN_H integral image from a raster-order
// pixel stream, pulses START when the window is complete and freezes the buffer until ACK.
module haar_integral_builder #(
    parameter int WIN_W = 20,
    parameter int WIN_H = 20,
    parameter int PIX_W = 8,
    parameter int ACC_W = 32
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         PIX_VALID,
    output logic                         PIX_READY,
    input  logic [PIX_W-1:0]             PIX_DATA,
    input  logic                         PIX_FIRST,
    input  logic                         ACK,
    output logic                         START,
    output logic                         BUSY,
    output logic [WIN_W*WIN_H*ACC_W-1:0] integral_buffer
);
    // state   | meaning
    // S_IDLE  | no window in progress, next accept is index 0
    // S_FILL  | accumulating pixels into the buffer
    // S_READY | window complete, buffer frozen until ACK
    localparam int DEPTH = WIN_W * WIN_H;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int X_W   = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int Y_W   = (WIN_H > 1) ? $clog2(WIN_H) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(WIN_W - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [ACC_W-1:0] row_sum_q, row_sum_d;
    logic             start_q, start_d;
    logic [ACC_W-1:0] buf_q [DEPTH];

    logic             accept;
    logic [IDX_W-1:0] wr_idx;
    logic [X_W-1:0]   wr_x;
    logic [Y_W-1:0]   wr_y;
    logic [IDX_W-1:0] above_idx;
    logic [ACC_W-1:0] above;
    logic [ACC_W-1:0] rs_new;
    logic [ACC_W-1:0] wr_val;

    assign PIX_READY = (state_q != S_READY);
    assign BUSY      = (state_q != S_IDLE);
    assign START     = start_q;
    assign accept    = PIX_VALID && PIX_READY;

    // PIX_FIRST forces the accepted pixel to be treated as index 0 of a fresh window
    assign wr_idx    = PIX_FIRST ? '0 : idx_q;
    assign wr_x      = PIX_FIRST ? '0 : x_q;
    assign wr_y      = PIX_FIRST ? '0 : y_q;

    assign rs_new    = ((wr_x == '0) ? '0 : row_sum_q) + ACC_W'(PIX_DATA);
    assign above_idx = (wr_y == '0) ? '0 : (wr_idx - IDX_W'(WIN_W));
    assign above     = (wr_y == '0) ? '0 : buf_q[above_idx];
    assign wr_val    = rs_new + above;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        row_sum_d = row_sum_q;
        start_d   = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    row_sum_d = rs_new;
                    if (wr_idx == IDX_LAST) begin
                        state_d = S_READY;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                        idx_d   = wr_idx + IDX_W'(1);
                        if (wr_x == X_LAST) begin
                            x_d = '0;
                            y_d = wr_y + Y_W'(1);
                        end else begin
                            x_d = wr_x + X_W'(1);
                            y_d = wr_y;
                        end
                    end
                end
            end
            S_READY: begin
                if (ACK) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    x_d       = '0;
                    y_d       = '0;
                    row_sum_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            row_sum_q <= '0;
            start_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_sum_q <= row_sum_d;
            start_q   <= start_d;
            if (accept) begin
                buf_q[wr_idx] <= wr_val;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign integral_buffer[g*ACC_W +: ACC_W] = buf_q[g];
    end

endmodule
